// File: rtl/xa_stream_decoder.sv
// xa_stream_decoder
//  Receive-side decoder for a stateful XOR/AND combiner. The combiner starts
//  with c=0. When its previous c was 0 it emits c=a^b, and when its previous
//  c was 1 it emits c=a&b. This block follows the combiner's mode from the
//  observed (b,c) stream and recovers a. It flags samples where a is
//  ambiguous, and samples the combiner cannot produce.
//
// Ports
//  clk, rst_n            clock, synchronous active-low reset
//  in_valid/in_ready     (b,c) sample handshake; in_ready = !out_valid | out_ready
//  in_b, in_c            combiner input b and combiner output c
//  resync                force the tracked mode back to 0 at the next edge
//  out_valid/out_ready   decoded-sample handshake (1-entry output register)
//  out_a, out_known      recovered a; out_known=0 means ambiguous or illegal
//  err                   sticky illegal-sample flag
//  amb_count             ambiguous-sample count, saturating
//  sample_count          accepted-sample count, wrapping
module xa_stream_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             resync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_known,
  output logic             err,
  output logic [CNT_W-1:0] amb_count,
  output logic [CNT_W-1:0] sample_count
);

  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_a_q, out_a_d;
  logic             out_known_q, out_known_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] amb_q, amb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_known_d = out_known_q;
    err_d       = err_q;
    amb_d       = amb_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + 1'b1;
      // The combiner's next mode is simply the c it just produced, illegal or not.
      mode_d      = in_c;
      if (!mode_q) begin
        out_a_d     = in_c ^ in_b;
        out_known_d = 1'b1;
      end else if (in_b) begin
        out_a_d     = in_c;
        out_known_d = 1'b1;
      end else begin
        // AND mode with b=0: c must be 0 and then a could be either value.
        out_a_d     = 1'b0;
        out_known_d = 1'b0;
        if (in_c) begin
          err_d = 1'b1;
        end else if (amb_q != {CNT_W{1'b1}}) begin
          amb_d = amb_q + 1'b1;
        end
      end
    end

    // resync wins over the mode update, but the sample above used the old mode.
    if (resync) begin
      mode_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= 1'b0;
      out_known_q <= 1'b0;
      err_q       <= 1'b0;
      amb_q       <= '0;
      cnt_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_known_q <= out_known_d;
      err_q       <= err_d;
      amb_q       <= amb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_a        = out_a_q;
  assign out_known    = out_known_q;
  assign err          = err_q;
  assign amb_count    = amb_q;
  assign sample_count = cnt_q;

endmodule
